prbs_chk: RTL and testbench

- Self-synchronising PRBS checker that sits directly downstream of the PRBS generator.
- Consumes the serial bit stream and its valid strobe, predicts each bit from the previously received bits using the same polynomial set, and acquires lock.
- Reports bit and error counts plus the lock status for link BER tests.
- Polynomial and tap set match the generator exactly, selected by the same PRBS_TYPE encoding.

---
 rtl/prbs_chk_if.sv | 16 +
 rtl/prbs_chk.sv | 153 +++++++++++++++
 tb/tb_prbs_chk.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_chk_if.sv
// Serial PRBS stream plus checker status, shared by the stream source and prbs_chk.
interface prbs_chk_if;
  logic        din;
  logic        din_vld;
  logic        cnt_clr;
  logic        lock;
  logic        err_pulse;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;
  logic [31:0] chk_shift_reg;

  modport master (output din, din_vld, cnt_clr,
                  input  lock, err_pulse, err_cnt, bit_cnt, chk_shift_reg);
  modport slave  (input  din, din_vld, cnt_clr,
                  output lock, err_pulse, err_cnt, bit_cnt, chk_shift_reg);
endinterface

// File: rtl/prbs_chk.sv
// Self-synchronising PRBS checker: predicts each bit from received history,
// hunts for lock, then counts bits/errors and drops lock on a bad window.
module prbs_chk #(
  parameter int PRBS_TYPE = 7,
  parameter int LOCK_CNT  = 16,
  parameter int WIN_LEN   = 1024,
  parameter int LOL_ERRS  = 64
) (
  input logic       clk,
  input logic       rst,
  prbs_chk_if.slave bus
);
  localparam int DEG = (PRBS_TYPE == 0) ? 3  : (PRBS_TYPE == 1) ? 7  :
                       (PRBS_TYPE == 2) ? 9  : (PRBS_TYPE == 3) ? 11 :
                       (PRBS_TYPE == 4) ? 15 : (PRBS_TYPE == 5) ? 17 :
                       (PRBS_TYPE == 6) ? 23 : 32;
  localparam logic [63:0] DMASK64 = (64'd1 << DEG) - 64'd1;
  localparam logic [31:0] DMASK   = DMASK64[31:0];
  localparam logic [5:0]  DEG_F   = 6'(DEG);
  localparam logic [8:0]  LOCK_N  = 9'(LOCK_CNT);
  localparam logic [16:0] WIN_N   = 17'(WIN_LEN);
  localparam logic [16:0] LOL_N   = 17'(LOL_ERRS);

  generate
    if (PRBS_TYPE < 0 || PRBS_TYPE > 7 || LOCK_CNT < 1 || LOCK_CNT > 255 ||
        WIN_LEN < 2 || WIN_LEN > 65535 || LOL_ERRS < 1 || LOL_ERRS > WIN_LEN) begin : g_bad_param
      $error("prbs_chk: illegal parameter set");
    end
  endgenerate

  typedef enum logic {HUNT, LOCKED} state_t;

  function automatic logic taps(input logic [31:0] h);
    case (PRBS_TYPE)
      0:       return h[2]  ^ h[0];
      1:       return h[6]  ^ h[0];
      2:       return h[8]  ^ h[4];
      3:       return h[10] ^ h[8];
      4:       return h[14] ^ h[0];
      5:       return h[16] ^ h[2];
      6:       return h[22] ^ h[17];
      default: return h[31] ^ h[21] ^ h[1] ^ h[0];
    endcase
  endfunction

  state_t      st_q, st_d;
  logic [31:0] h_q, h_d, h_sh;
  logic [5:0]  fill_q, fill_d;
  logic [7:0]  match_q, match_d;
  logic [15:0] win_q, win_d, wec_q, wec_d;
  logic [31:0] err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;
  logic        pulse_q, pulse_d;
  logic        pred, err_bit, full, zero;
  logic [8:0]  match_inc;
  logic [16:0] win_inc, wec_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= HUNT;
      h_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      wec_q     <= '0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_q     <= win_d;
      wec_q     <= wec_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    h_sh      = {h_q[30:0], bus.din};
    pred      = taps(h_q);
    err_bit   = bus.din ^ pred;
    full      = (fill_q == DEG_F);
    // A history window of all zeros predicts zeros forever; never count it as a match.
    zero      = ((h_sh & DMASK) == 32'd0);
    match_inc = {1'b0, match_q} + 9'd1;
    win_inc   = {1'b0, win_q} + 17'd1;
    wec_inc   = {1'b0, wec_q} + {16'd0, err_bit};

    st_d      = st_q;
    h_d       = h_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_d     = win_q;
    wec_d     = wec_q;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    pulse_d   = 1'b0;

    if (bus.din_vld) begin
      h_d = h_sh;
      if (!full) fill_d = fill_q + 6'd1;
      case (st_q)
        HUNT: begin
          if (zero || (full && err_bit)) begin
            match_d = '0;
          end else if (full) begin
            match_d = match_inc[7:0];
            if (match_inc == LOCK_N) begin
              st_d  = LOCKED;
              win_d = '0;
              wec_d = '0;
            end
          end
        end
        default: begin
          pulse_d = err_bit;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 32'd1;
          if (err_bit && err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
          if (wec_inc == LOL_N) begin
            st_d    = HUNT;
            match_d = '0;
          end else if (win_inc == WIN_N) begin
            win_d = '0;
            wec_d = '0;
          end else begin
            win_d = win_inc[15:0];
            wec_d = wec_inc[15:0];
          end
        end
      endcase
    end

    // Clear wins over increment, but the bit checked this cycle still counts.
    if (bus.cnt_clr) begin
      if (bus.din_vld && st_q == LOCKED) begin
        bit_cnt_d = 32'd1;
        err_cnt_d = {31'd0, err_bit};
      end else begin
        bit_cnt_d = '0;
        err_cnt_d = '0;
      end
    end
  end

  assign bus.lock          = (st_q == LOCKED);
  assign bus.err_pulse     = pulse_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.bit_cnt       = bit_cnt_q;
  assign bus.chk_shift_reg = h_q;
endmodule

// File: tb/tb_prbs_chk.sv
// Randomised bench for prbs_chk: a type-0 and a type-7 checker see the same stream
// and are compared every cycle against a bit-history reference model.
module tb_prbs_chk;
  localparam int LOCKC = 16;
  localparam int WINL  = 1024;
  localparam int LOLE  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs_chk_if if0 ();
  prbs_chk_if if7 ();

  prbs_chk #(.PRBS_TYPE(0), .LOCK_CNT(LOCKC), .WIN_LEN(WINL), .LOL_ERRS(LOLE))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  prbs_chk #(.PRBS_TYPE(7), .LOCK_CNT(LOCKC), .WIN_LEN(WINL), .LOL_ERRS(LOLE))
    dut7 (.clk(clk), .rst(rst), .bus(if7));

  int nchk = 0;
  int nerr = 0;

  // reference model state, index 0 = type 0, index 1 = type 7
  bit [63:0] hist [2];
  int        mn [2];
  bit        mlock [2];
  int        mmatch [2];
  bit [31:0] mbit [2];
  bit [31:0] merr [2];
  int        mwin [2];
  int        mwec [2];
  bit        mpulse [2];
  // line generators
  bit [63:0] g [2];
  int        gn [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int deg_of(input int k);
    return (k == 0) ? 3 : 32;
  endfunction

  function automatic bit rb(input bit [63:0] r, input int n);
    bit [5:0] i;
    i = 6'(n % 64);
    return r[i];
  endfunction

  // next bit of the sequence given the bits seen so far (bit at lag L = r[n-L])
  function automatic bit lagx(input int k, input bit [63:0] r, input int n);
    if (k == 0) return rb(r, n - 3) ^ rb(r, n - 1);
    return rb(r, n - 32) ^ rb(r, n - 22) ^ rb(r, n - 2) ^ rb(r, n - 1);
  endfunction

  task automatic gen(input int k, output bit b);
    bit [5:0] wi;
    b = lagx(k, g[k], gn[k]);
    wi = 6'(gn[k] % 64);
    g[k][wi] = b;
    gn[k]++;
  endtask

  task automatic mdl_rst();
    for (int k = 0; k < 2; k++) begin
      hist[k] = '0; mn[k] = 0; mlock[k] = 0; mmatch[k] = 0;
      mbit[k] = 0; merr[k] = 0; mwin[k] = 0; mwec[k] = 0; mpulse[k] = 0;
    end
  endtask

  task automatic mdl_step(input int k, input bit d, input bit v, input bit c);
    int dg;
    bit pred, e, z, lk, had;
    bit [5:0] wi;
    dg = deg_of(k);
    lk = mlock[k];
    mpulse[k] = 0;
    e = 0;
    if (v) begin
      had  = (mn[k] >= dg);
      pred = had ? lagx(k, hist[k], mn[k]) : 1'b0;
      e    = d ^ pred;
      wi   = 6'(mn[k] % 64);
      hist[k][wi] = d;
      mn[k]++;
      z = 1;
      for (int i = 0; i < dg; i++)
        if (mn[k] - 1 - i >= 0 && rb(hist[k], mn[k] - 1 - i)) z = 0;
      if (!lk) begin
        if (z || (had && e)) mmatch[k] = 0;
        else if (had) begin
          mmatch[k]++;
          if (mmatch[k] == LOCKC) begin mlock[k] = 1; mwin[k] = 0; mwec[k] = 0; end
        end
      end else begin
        mpulse[k] = e;
        mwin[k]++;
        mwec[k] += int'(e);
        if (mwec[k] == LOLE) begin mlock[k] = 0; mmatch[k] = 0; end
        else if (mwin[k] == WINL) begin mwin[k] = 0; mwec[k] = 0; end
      end
    end
    if (v && lk) begin
      if (c) begin mbit[k] = 1; merr[k] = {31'd0, e}; end
      else begin
        if (mbit[k] != '1) mbit[k]++;
        if (e && merr[k] != '1) merr[k]++;
      end
    end else if (c) begin
      mbit[k] = 0; merr[k] = 0;
    end
  endtask

  function automatic bit [31:0] mdl_h(input int k);
    bit [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (mn[k] - 1 - i >= 0) r[i] = rb(hist[k], mn[k] - 1 - i);
    return r;
  endfunction

  task automatic cmp_all();
    chk("d0_lock",  64'(if0.lock),          64'(mlock[0]));
    chk("d0_pulse", 64'(if0.err_pulse),     64'(mpulse[0]));
    chk("d0_errc",  64'(if0.err_cnt),       64'(merr[0]));
    chk("d0_bitc",  64'(if0.bit_cnt),       64'(mbit[0]));
    chk("d0_hreg",  64'(if0.chk_shift_reg), 64'(mdl_h(0)));
    chk("d7_lock",  64'(if7.lock),          64'(mlock[1]));
    chk("d7_pulse", 64'(if7.err_pulse),     64'(mpulse[1]));
    chk("d7_errc",  64'(if7.err_cnt),       64'(merr[1]));
    chk("d7_bitc",  64'(if7.bit_cnt),       64'(mbit[1]));
    chk("d7_hreg",  64'(if7.chk_shift_reg), 64'(mdl_h(1)));
  endtask

  task automatic drive(input bit v, input bit d, input bit c);
    if0.din_vld = v; if0.din = d; if0.cnt_clr = c;
    if7.din_vld = v; if7.din = d; if7.cnt_clr = c;
  endtask

  task automatic step(input bit v, input bit d, input bit c);
    drive(v, d, c);
    @(posedge clk);
    #1;
    mdl_step(0, d, v, c);
    mdl_step(1, d, v, c);
    cmp_all();
  endtask

  // asynchronous: outputs must read zero before any clock edge
  task automatic do_rst();
    drive(0, 0, 0);
    rst = 1'b1;
    #1;
    mdl_rst();
    cmp_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic feed(input int k, input int n);
    bit b;
    for (int i = 0; i < n; i++) begin gen(k, b); step(1, b, 0); end
  endtask

  initial begin
    bit b, v, c, dropped, relocked;
    bit [63:0] mask, exp_mask;

    for (int k = 0; k < 2; k++) begin
      g[k] = {$urandom, $urandom};
      g[k][63] = 1'b1;
      gn[k] = 64;
    end
    drive(0, 0, 0);
    mdl_rst();
    #2;
    do_rst();

    // type 0 acquisition: 3 fill bits + 16 matches
    for (int i = 1; i <= 19; i++) begin
      gen(0, b); step(1, b, 0);
      if (i == 18) chk("lock_at_18", 64'(if0.lock), 64'd0);
      if (i == 19) chk("lock_at_19", 64'(if0.lock), 64'd1);
    end
    feed(0, 1000);
    chk("clean_errc", 64'(if0.err_cnt), 64'd0);
    chk("clean_bitc", 64'(if0.bit_cnt), 64'd1000);

    // type 7 single flipped bit
    do_rst();
    feed(1, 60);
    chk("t7_locked", 64'(if7.lock), 64'd1);
    mask = '0;
    for (int j = 0; j < 40; j++) begin
      gen(1, b);
      if (j == 0) b = ~b;
      step(1, b, 0);
      if (if7.err_pulse) mask[j] = 1'b1;
    end
    exp_mask = '0;
    exp_mask[0] = 1; exp_mask[1] = 1; exp_mask[2] = 1; exp_mask[22] = 1; exp_mask[32] = 1;
    chk("t7_pulses", mask, exp_mask);
    chk("t7_errc", 64'(if7.err_cnt), 64'd5);
    chk("t7_lock_held", 64'(if7.lock), 64'd1);

    // type 0 flipped bit with gapped valid
    do_rst();
    feed(0, 25);
    chk("gap_locked", 64'(if0.lock), 64'd1);
    for (int j = 0; j < 60; j++) begin
      v = (j % 2 == 0);
      if (v) begin gen(0, b); if (j == 0) b = ~b; end
      else b = 1'($urandom_range(0, 1));
      step(v, b, 0);
    end
    chk("gap_errc", 64'(if0.err_cnt), 64'd3);

    // loss of lock under 50% errors, then relock on a clean stream
    dropped = 0;
    for (int i = 0; i < WINL && !dropped; i++) begin
      gen(0, b);
      step(1, b ^ 1'($urandom_range(0, 1)), 0);
      if (!if0.lock) dropped = 1;
    end
    chk("lol_drop", 64'(dropped), 64'd1);
    relocked = 0;
    for (int i = 0; i < 3 + LOCKC && !relocked; i++) begin
      gen(0, b); step(1, b, 0);
      if (if0.lock) relocked = 1;
    end
    chk("relock", 64'(relocked), 64'd1);

    // random valid gaps, clears and sparse line errors
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      if (v) begin gen(0, b); if ($urandom_range(0, 99) == 0) b = ~b; end
      else b = 1'($urandom_range(0, 1));
      step(v, b, c);
    end

    // dead line never locks
    do_rst();
    for (int i = 0; i < 500; i++) step(1, 0, 0);
    chk("zero_lock0", 64'(if0.lock), 64'd0);
    chk("zero_lock7", 64'(if7.lock), 64'd0);
    chk("zero_bitc0", 64'(if0.bit_cnt), 64'd0);
    chk("zero_errc7", 64'(if7.err_cnt), 64'd0);

    // clear coincident with an errored locked bit, then reset mid-lock
    do_rst();
    feed(0, 25);
    chk("clr_locked", 64'(if0.lock), 64'd1);
    gen(0, b);
    step(1, ~b, 1);
    chk("clr_errc", 64'(if0.err_cnt), 64'd1);
    chk("clr_bitc", 64'(if0.bit_cnt), 64'd1);
    feed(0, 10);
    do_rst();
    chk("rst_lock", 64'(if0.lock), 64'd0);
    chk("rst_hreg", 64'(if0.chk_shift_reg), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
